// File: rtl/bpredict_upd_ctrl.sv
// bpredict_upd_ctrl: queues branch resolutions and drains them into the predictor update port, with an invalidate sweep on request.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
module bpredict_upd_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int FIFO_LOG2  = 2
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_res_valid,
  output logic                  ow_res_ready,
  input  logic [`SIZE_ADDR-1:0] iw_res_pc,
  input  logic                  iw_res_taken,
  input  logic [`SIZE_ADDR-1:0] iw_res_target,
  input  logic                  iw_hold,
  input  logic                  iw_flush_req,
  output logic                  ow_flush_busy,
  output logic                  ow_flush_done,
  output logic                  ow_update,
  output logic [`SIZE_ADDR-1:0] ow_update_pc,
  output logic                  ow_actual_taken,
  output logic [`SIZE_ADDR-1:0] ow_actual_target,
  output logic [FIFO_LOG2:0]    ow_fifo_count
);
  localparam int AW = `SIZE_ADDR;
  localparam int DEPTH = 2**FIFO_LOG2;
  localparam int ENTRY_NUM = 2**INDEX_BITS;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t r_state, w_state_next;
  logic [AW-1:0] r_pc_q [DEPTH];
  logic [AW-1:0] r_tgt_q [DEPTH];
  logic [DEPTH-1:0] r_tk_q;
  logic [FIFO_LOG2-1:0] r_wr, r_rd;
  logic [FIFO_LOG2:0] r_count;
  logic [INDEX_BITS-1:0] r_idx;
  logic r_update, r_taken, r_busy, r_done;
  logic [AW-1:0] r_upc, r_tgt;
  logic w_flush, w_push, w_pop, w_last;
  // full exactly when the occupancy MSB is set, since count never exceeds DEPTH
  assign ow_res_ready = (r_state == IDLE) && !r_busy && !r_count[FIFO_LOG2] && !iw_flush_req;
  assign w_flush = (r_state == IDLE) && !r_busy && iw_flush_req;
  assign w_push = iw_res_valid && ow_res_ready;
  assign w_pop = (r_state == IDLE) && !w_flush && !iw_hold && (r_count != '0);
  assign w_last = r_idx == INDEX_BITS'(ENTRY_NUM - 1);
  always_comb begin
    w_state_next = w_flush ? SWEEP : ((r_state == SWEEP) && w_last) ? IDLE : r_state;
  end
  always_ff @(posedge iw_clk) begin
    if (w_push) begin
      r_pc_q[r_wr] <= iw_res_pc;
      r_tgt_q[r_wr] <= iw_res_target;
      r_tk_q[r_wr] <= iw_res_taken;
    end
  end
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_state <= IDLE;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_idx <= '0;
      r_update <= 1'b0;
      r_upc <= '0;
      r_taken <= 1'b0;
      r_tgt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done <= 1'b0;
      if (w_flush) begin
        r_wr <= '0;
        r_rd <= '0;
        r_count <= '0;
      end else begin
        r_wr <= r_wr + FIFO_LOG2'(w_push);
        r_rd <= r_rd + FIFO_LOG2'(w_pop);
        r_count <= r_count + (FIFO_LOG2+1)'(w_push) - (FIFO_LOG2+1)'(w_pop);
      end
      if (w_flush) begin
        r_update <= 1'b1;
        r_upc <= '0;
        r_taken <= 1'b0;
        r_tgt <= '0;
        r_busy <= 1'b1;
        r_idx <= INDEX_BITS'(1);
      end else if (r_state == SWEEP) begin
        r_update <= 1'b1;
        r_upc <= AW'(r_idx);
        r_taken <= 1'b0;
        r_tgt <= '0;
        r_idx <= r_idx + 1'b1;
        r_done <= w_last;
      end else begin
        r_busy <= 1'b0;
        r_update <= w_pop;
        if (w_pop) begin
          r_upc <= r_pc_q[r_rd];
          r_taken <= r_tk_q[r_rd];
          r_tgt <= r_tgt_q[r_rd];
        end
      end
    end
  end
  assign ow_update = r_update;
  assign ow_update_pc = r_upc;
  assign ow_actual_taken = r_taken;
  assign ow_actual_target = r_tgt;
  assign ow_flush_busy = r_busy;
  assign ow_flush_done = r_done;
  assign ow_fifo_count = r_count;
endmodule

// File: tb/tb_bpredict_upd_ctrl.sv
// tb_bpredict_upd_ctrl: directed and random stimulus checked against a queue-based model of the update sequencer.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
module tb_bpredict_upd_ctrl;
  localparam int AW = `SIZE_ADDR;
  localparam int DEPTH = 4;
  localparam int ENTRIES = 16;
  logic clk = 1'b0;
  logic rst, res_valid, res_taken, hold, flush_req;
  logic [AW-1:0] res_pc, res_target;
  logic res_ready, flush_busy, flush_done, update, actual_taken;
  logic [AW-1:0] update_pc, actual_target;
  logic [2:0] fifo_count;
  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  typedef struct {logic [AW-1:0] pc; logic tk; logic [AW-1:0] tg;} ent_t;
  ent_t q[$];
  int sw_next = -1;
  logic e_update = 0, e_taken = 0, e_busy = 0, e_done = 0;
  logic [AW-1:0] e_pc = '0, e_tg = '0;
  always #5 clk = ~clk;
  bpredict_upd_ctrl #(.INDEX_BITS(4), .FIFO_LOG2(2)) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_res_valid(res_valid), .ow_res_ready(res_ready),
    .iw_res_pc(res_pc), .iw_res_taken(res_taken), .iw_res_target(res_target),
    .iw_hold(hold), .iw_flush_req(flush_req), .ow_flush_busy(flush_busy),
    .ow_flush_done(flush_done), .ow_update(update), .ow_update_pc(update_pc),
    .ow_actual_taken(actual_taken), .ow_actual_target(actual_target),
    .ow_fifo_count(fifo_count)
  );
  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic m_ready(input logic f);
    return sw_next < 0 && !e_busy && q.size() < DEPTH && !f;
  endfunction
  // one clock: drive at negedge, predict the edge, compare the registered result at the next negedge
  task automatic cyc(input logic v, input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg,
                     input logic h, input logic f, input logic r);
    logic push;
    ent_t e;
    rst = r; res_valid = v; res_pc = pc; res_taken = tk; res_target = tg; hold = h; flush_req = f;
    #1;
    push = v && m_ready(f);
    if (!r) chk("ready", AW'(res_ready), AW'(m_ready(f)));
    e_done = 0;
    if (r) begin
      q.delete(); sw_next = -1;
      e_update = 0; e_pc = '0; e_taken = 0; e_tg = '0; e_busy = 0;
    end else if (sw_next < 0 && !e_busy && f) begin
      q.delete(); sw_next = 1;
      e_update = 1; e_pc = '0; e_taken = 0; e_tg = '0; e_busy = 1;
    end else if (sw_next >= 0) begin
      e_update = 1; e_pc = AW'(sw_next); e_taken = 0; e_tg = '0;
      e_done = (sw_next == ENTRIES - 1);
      sw_next = e_done ? -1 : sw_next + 1;
    end else begin
      e_busy = 0;
      e_update = !h && q.size() > 0;
      if (e_update) begin
        e = q.pop_front();
        e_pc = e.pc; e_taken = e.tk; e_tg = e.tg;
      end
      if (push) q.push_back('{pc, tk, tg});
    end
    @(posedge clk);
    @(negedge clk);
    if (flush_done) done_pulses++;
    chk("update", AW'(update), AW'(e_update));
    chk("busy", AW'(flush_busy), AW'(e_busy));
    chk("done", AW'(flush_done), AW'(e_done));
    chk("count", AW'(fifo_count), AW'(q.size()));
    if (e_update) begin
      chk("pc", update_pc, e_pc);
      chk("taken", AW'(actual_taken), AW'(e_taken));
      chk("target", actual_target, e_tg);
    end
  endtask
  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, h, 0, 0);
  endtask
  initial begin
    int pulses;
    rst = 1; res_valid = 0; res_pc = '0; res_taken = 0; res_target = '0; hold = 0; flush_req = 0;
    cyc(0, '0, 0, '0, 0, 0, 1);
    cyc(0, '0, 0, '0, 0, 0, 1);
    chk("rst_pc", update_pc, '0);
    chk("rst_target", actual_target, '0);
    chk("rst_taken", AW'(actual_taken), '0);
    idle(1, 0);
    cyc(1, 16'h0013, 1, 16'h0040, 0, 0, 0);
    idle(3, 0);
    for (int i = 0; i < 5; i++) cyc(1, AW'(16'h100 + i), i[0], AW'(16'h200 + i), 1, 0, 0);
    chk("full_count", AW'(fifo_count), AW'(4));
    for (int i = 0; i < 3; i++) cyc(1, 16'h104, 0, 16'h204, 0, 0, 0);
    idle(4, 0);
    cyc(1, 16'h0aaa, 1, 16'h0bbb, 1, 0, 0);
    cyc(1, 16'h0ccc, 0, 16'h0ddd, 1, 0, 0);
    pulses = done_pulses;
    cyc(0, '0, 0, '0, 1, 1, 0);
    for (int i = 0; i < 19; i++) cyc(0, '0, 0, '0, i[0], 1, 0);
    chk("sweep_done_pulses", AW'(done_pulses - pulses), AW'(1));
    cyc(1, 16'h0777, 1, 16'h0888, 0, 1, 0);
    idle(18, 0);
    cyc(0, '0, 0, '0, 0, 1, 0);
    idle(5, 0);
    chk("sweep_pc5", update_pc, AW'(5));
    pulses = done_pulses;
    cyc(0, '0, 0, '0, 0, 0, 1);
    idle(20, 0);
    chk("abort_no_done", AW'(done_pulses - pulses), '0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6, AW'($urandom), 1'($urandom), AW'($urandom),
          $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpredict_upd_ctrl.md
Name: bpredict_upd_ctrl

Overview:
Sequencer for the branch predictor's single update port. Buffers branch-resolution updates from the execute stage in a small FIFO and drains them at one write per cycle. Runs an invalidate sweep on request, writing not-taken with target 0 to every predictor entry. Sits between execute-stage branch resolution and the bpredict update inputs. It drives update, update_pc, actual_taken and actual_target.

Parameters:
INDEX_BITS, 4, predictor index width; the sweep covers ENTRY_NUM = 2**INDEX_BITS entries; must match the predictor instance.
FIFO_LOG2, 2, log2 of the resolution FIFO depth (default depth 4).

Ports:
iw_clk  input  1  clock; single clock domain.
iw_rst  input  1  reset; synchronous, active-high.
iw_res_valid  input  1  execute stage presents a resolved branch.
ow_res_ready  output  1  controller accepts the resolution this cycle.
iw_res_pc  input  `SIZE_ADDR  PC of the resolved branch.
iw_res_taken  input  1  actual direction.
iw_res_target  input  `SIZE_ADDR  actual target.
iw_hold  input  1  freeze FIFO draining; does not affect the sweep.
iw_flush_req  input  1  request an invalidate sweep; sampled per cycle.
ow_flush_busy  output  1  a sweep write is presented this cycle.
ow_flush_done  output  1  one-cycle pulse coinciding with the final sweep write.
ow_update  output  1  write strobe to the predictor.
ow_update_pc  output  `SIZE_ADDR  write PC.
ow_actual_taken  output  1  write direction.
ow_actual_target  output  `SIZE_ADDR  write target.
ow_fifo_count  output  FIFO_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous): state IDLE, FIFO empty, sweep index 0.
  - All registered outputs are 0: ow_update, ow_update_pc, ow_actual_taken, ow_actual_target, ow_flush_busy, ow_flush_done, ow_fifo_count.
  - Reset during a sweep aborts it. ow_flush_done is not pulsed.
- States are IDLE and SWEEP. All ow_update* outputs, ow_flush_busy and ow_flush_done are registered.
- ow_res_ready is combinational: (state == IDLE) && !ow_flush_busy && (count < depth) && !iw_flush_req.
- A transfer occurs when iw_res_valid && ow_res_ready at a rising edge. The entry is pushed at that edge.
- Drain in IDLE, when there is no flush, !iw_hold and the FIFO is non-empty:
  - At the edge, the head is popped into the output registers and ow_update = 1 for the following cycle.
  - Otherwise ow_update = 0.
  - An entry accepted at edge k with the FIFO empty appears on ow_update in the cycle after edge k+1. Latency is 2 edges.
  - Sustained throughput is one update per cycle.
- Push and pop on the same edge: count is unchanged. Push and pop never alias the same slot. No push occurs when full, because ready is low.
- Pointers wrap modulo depth. Count saturates at neither end; underflow and overflow are impossible by construction.
- Flush start: at an edge in IDLE with iw_flush_req = 1:
  - The FIFO is cleared and its pending entries are discarded (never written).
  - No pop occurs on that edge.
  - state <= SWEEP.
  - Outputs load update = 1, pc = 0, taken = 0, target = 0. busy <= 1. index <= 1.
- SWEEP, at each edge:
  - Outputs load update = 1, pc = index zero-extended to `SIZE_ADDR, taken = 0, target = 0. index increments.
  - When the loaded index is ENTRY_NUM-1: ow_flush_done <= 1 for that cycle only, and state <= IDLE.
  - At the next edge busy <= 0, and ow_update <= 0 unless a drain applies (the FIFO is empty).
  - ow_flush_busy is high for exactly ENTRY_NUM consecutive cycles.
- iw_flush_req while busy is ignored; the sweep does not restart. iw_flush_req and iw_res_valid together in IDLE: flush wins, ready is low, and the resolution is not accepted.
- iw_hold does not stall the sweep. iw_hold in IDLE holds the FIFO and drives ow_update to 0 while pushes continue until the FIFO is full.

Test Plan:
- Reset -> every output is 0 and ow_res_ready = 1 the cycle after reset deasserts.
- One resolution (pc=0x0013, taken=1, target=0x0040) accepted at edge k -> ow_update=1, pc=0x0013, taken=1, target=0x0040 in the cycle after edge k+1, high for exactly 1 cycle.
- iw_hold=1 while 5 back-to-back resolutions are offered (depth 4) -> 4 accepted, fifo_count=4, ready=0 on the 5th. Release hold -> 4 consecutive updates in push order, then the 5th is accepted.
- 2 entries queued under hold, then a flush_req pulse (INDEX_BITS=4) -> 16 consecutive writes with pc 0..15, taken=0, target=0. busy is high for 16 cycles, done is high only in the 16th, the queued entries are never written, and count=0.
- flush_req and res_valid in the same cycle -> ready=0, the resolution is not accepted, and the sweep starts at pc 0.
- Reset asserted during the 6th sweep write -> next cycle update=0, busy=0, done never pulses, ready=1 after reset.
